fp_div_seq: RTL and testbench

- Iterative IEEE-754 single-precision divider, z = a / b. It is the inverse-operation companion to the combinational FP multiplier and shares its rounding-mode enum and status byte format.
- Uses radix-2 restoring mantissa division over multiple cycles, behind valid/ready handshakes on both input and output.
- Sits beside the multiplier in the FP datapath. One operation is in flight at a time.

---
 rtl/fp_div_pkg.sv | 25 ++
 rtl/rnd_enum.sv | 13 +
 rtl/fp_div_seq_if.sv | 26 ++
 rtl/fp_div_seq_round_div.sv | 35 +++
 rtl/fp_div_seq.sv | 208 ++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative single-precision divider.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int BIAS  = 127;
    localparam int QBITS = 26;

    // Bit positions inside the status byte.
    localparam int ST_ZERO        = 0;
    localparam int ST_INF         = 1;
    localparam int ST_NAN         = 2;
    localparam int ST_TINY        = 3;
    localparam int ST_HUGE        = 4;
    localparam int ST_INEXACT     = 5;
    localparam int ST_DIV_BY_ZERO = 6;

    localparam logic [31:0] NAN_CANON = 32'h7FC0_0000;

endpackage

// File: rtl/rnd_enum.sv
// Rounding-mode encoding shared by the FP multiplier and divider.
package rnd_enum;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } rnd_t;

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result bus of the divider with producer (master) and divider (slave) views.
interface fp_div_seq_if;

    // A transfer happens on a rising edge where valid && ready; the sender
    // holds its payload stable while valid is high and ready is low.
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] z;
    logic [7:0]  status;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, b, rnd, in_valid, out_ready,
        input  in_ready, z, status, out_valid
    );

    modport slave (
        input  a, b, rnd, in_valid, out_ready,
        output in_ready, z, status, out_valid
    );

endinterface

// File: rtl/fp_div_seq_round_div.sv
// Rounds a 24-bit quotient significand from guard/sticky under the selected mode.
module round_div
    import rnd_enum::*;
(
    input  logic [23:0] i_mant,
    input  logic        i_guard,
    input  logic        i_sticky,
    input  logic        i_sign,
    input  rnd_t        i_rnd,
    output logic [24:0] o_mant,
    output logic        o_inexact
);

    logic w_inc;
    logic w_lost;

    assign w_lost = i_guard | i_sticky;

    always_comb begin
        w_inc = 1'b0;
        case (i_rnd)
            IEEE_near: w_inc = i_guard & (i_sticky | i_mant[0]);
            IEEE_zero: w_inc = 1'b0;
            IEEE_pinf: w_inc = ~i_sign & w_lost;
            IEEE_ninf: w_inc = i_sign & w_lost;
            near_up:   w_inc = i_guard & (i_sticky | ~i_sign);
            away_zero: w_inc = w_lost;
            default:   w_inc = 1'b0;
        endcase
    end

    assign o_mant    = {1'b0, i_mant} + {24'd0, w_inc};
    assign o_inexact = w_lost;

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider, radix-2 restoring, one op in flight.
// Optional macro FP_DIV_EARLY_TERM_EN ends DIVIDE as soon as the remainder is zero.
module fp_div_seq
    import fp_div_pkg::*;
    import rnd_enum::*;
(
    input  logic        clk,
    input  logic        rst,
    fp_div_seq_if.slave bus,
    output state_t      o_state
);

    state_t            r_state;
    state_t            w_next;
    logic [23:0]       r_den;
    logic [24:0]       r_rem;
    logic [QBITS-1:0]  r_q;
    logic [4:0]        r_cnt;
    logic              r_sign;
    logic signed [9:0] r_exp;
    rnd_t              r_rnd;
    logic [31:0]       r_z;
    logic [7:0]        r_status;

    // Operand classification; denormals collapse to zero.
    logic [7:0]  w_ea, w_eb;
    logic        w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero, w_sign_in;
    logic        w_special;
    logic [31:0] w_spec_z;
    logic [7:0]  w_spec_st;
    logic [9:0]  w_exp_init;

    assign w_ea      = bus.a[30:23];
    assign w_eb      = bus.b[30:23];
    assign w_a_nan   = (&w_ea) & (|bus.a[22:0]);
    assign w_a_inf   = (&w_ea) & ~(|bus.a[22:0]);
    assign w_a_zero  = (w_ea == 8'd0);
    assign w_b_nan   = (&w_eb) & (|bus.b[22:0]);
    assign w_b_inf   = (&w_eb) & ~(|bus.b[22:0]);
    assign w_b_zero  = (w_eb == 8'd0);
    assign w_sign_in = bus.a[31] ^ bus.b[31];
    assign w_exp_init = {2'b00, w_ea} - {2'b00, w_eb} + 10'(BIAS);

    always_comb begin
        w_special = 1'b1;
        w_spec_z  = 32'd0;
        w_spec_st = 8'd0;
        if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
            w_spec_z          = NAN_CANON;
            w_spec_st[ST_NAN] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_z          = {w_sign_in, 8'hFF, 23'd0};
            w_spec_st[ST_INF] = 1'b1;
        end else if (w_b_zero) begin
            w_spec_z                  = {w_sign_in, 8'hFF, 23'd0};
            w_spec_st[ST_INF]         = 1'b1;
            w_spec_st[ST_DIV_BY_ZERO] = 1'b1;
        end else if (w_a_zero | w_b_inf) begin
            w_spec_z           = {w_sign_in, 31'd0};
            w_spec_st[ST_ZERO] = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    // One restoring step: the remainder stays below 2*den, so 25 bits suffice.
    logic        w_ge;
    logic [23:0] w_diff;
    logic [24:0] w_rem_nxt;
    logic [4:0]  w_qidx;

    assign w_ge      = (r_rem >= {1'b0, r_den});
    assign w_diff    = r_rem[23:0] - r_den;
    assign w_rem_nxt = w_ge ? {w_diff, 1'b0} : {r_rem[23:0], 1'b0};
    assign w_qidx    = 5'(QBITS - 1) - r_cnt;

    // Normalise, round, renormalise on carry-out, then range-check.
    logic [23:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic [24:0]       w_rmant;
    logic              w_inexact;
    logic [22:0]       w_frac;
    logic signed [9:0] w_exp_n, w_exp_f;
    logic              w_away;
    logic [31:0]       w_rnd_z;
    logic [7:0]        w_rnd_st;

    assign w_mant   = r_q[QBITS-1] ? r_q[25:2] : r_q[24:1];
    assign w_guard  = r_q[QBITS-1] ? r_q[1]    : r_q[0];
    assign w_sticky = (r_rem != 25'd0);
    assign w_exp_n  = r_q[QBITS-1] ? r_exp : r_exp - 10'sd1;

    round_div u_round (
        .i_mant    (w_mant),
        .i_guard   (w_guard),
        .i_sticky  (w_sticky),
        .i_sign    (r_sign),
        .i_rnd     (r_rnd),
        .o_mant    (w_rmant),
        .o_inexact (w_inexact)
    );

    assign w_frac  = w_rmant[24] ? w_rmant[23:1] : w_rmant[22:0];
    assign w_exp_f = w_rmant[24] ? w_exp_n + 10'sd1 : w_exp_n;
    assign w_away  = ((r_rnd == IEEE_pinf) & ~r_sign) | ((r_rnd == IEEE_ninf) & r_sign);

    always_comb begin
        w_rnd_z              = {r_sign, w_exp_f[7:0], w_frac};
        w_rnd_st             = 8'd0;
        w_rnd_st[ST_INEXACT] = w_inexact;
        if (w_exp_f >= 10'sd255) begin
            w_rnd_st[ST_HUGE]    = 1'b1;
            w_rnd_st[ST_INEXACT] = 1'b1;
            if ((r_rnd == IEEE_near) | (r_rnd == near_up) | (r_rnd == away_zero) | w_away) begin
                w_rnd_z          = {r_sign, 8'hFF, 23'd0};
                w_rnd_st[ST_INF] = 1'b1;
            end else begin
                w_rnd_z = {r_sign, 8'hFE, {23{1'b1}}};
            end
        end else if (w_exp_f <= 10'sd0) begin
            w_rnd_st[ST_TINY]    = 1'b1;
            w_rnd_st[ST_INEXACT] = 1'b1;
            if ((r_rnd == away_zero) | w_away) begin
                w_rnd_z = {r_sign, 8'h01, 23'd0};
            end else begin
                w_rnd_z           = {r_sign, 31'd0};
                w_rnd_st[ST_ZERO] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (bus.in_valid) w_next = w_special ? DONE : DIVIDE;
            DIVIDE: begin
                if (r_cnt == 5'(QBITS - 1)) w_next = ROUND;
`ifdef FP_DIV_EARLY_TERM_EN
                else if (w_rem_nxt == 25'd0) w_next = ROUND;
`endif
            end
            ROUND:  w_next = DONE;
            DONE:   if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_den    <= 24'd0;
            r_rem    <= 25'd0;
            r_q      <= '0;
            r_cnt    <= 5'd0;
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_rnd    <= IEEE_near;
            r_z      <= 32'd0;
            r_status <= 8'd0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_den  <= {1'b1, bus.b[22:0]};
                    r_rem  <= {2'b01, bus.a[22:0]};
                    r_q    <= '0;
                    r_cnt  <= 5'd0;
                    r_sign <= w_sign_in;
                    r_exp  <= w_exp_init;
                    r_rnd  <= rnd_t'(bus.rnd);
                    if (w_special) begin
                        r_z      <= w_spec_z;
                        r_status <= w_spec_st;
                    end
                end
                DIVIDE: begin
                    r_rem       <= w_rem_nxt;
                    r_q[w_qidx] <= w_ge;
                    r_cnt       <= r_cnt + 5'd1;
                end
                ROUND: begin
                    r_z      <= w_rnd_z;
                    r_status <= w_rnd_st;
                end
                default: ;
            endcase
        end
    end

    assign bus.z      = r_z;
    assign bus.status = r_status;
    assign o_state    = r_state;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq against an integer-division reference model.
module tb_fp_div_seq;
  import fp_div_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t w_state;
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  logic [39:0] exp_q[$];

  fp_div_seq_if dut_if ();

  fp_div_seq dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (dut_if.slave),
    .o_state (w_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact quotient by integer division, rounding judged from the remainder.
  function automatic logic [39:0] model(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] rv);
    int ea, eb, e;
    logic s, an, ai, az, bn, bi, bz, up, away, exact, above, tie;
    longint na, den, num, n, rm;
    ea = int'(av[30:23]);
    eb = int'(bv[30:23]);
    s  = av[31] ^ bv[31];
    an = (ea == 255) && (av[22:0] != 0);
    ai = (ea == 255) && (av[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (bv[22:0] != 0);
    bi = (eb == 255) && (bv[22:0] == 0);
    bz = (eb == 0);
    if (an || bn || (az && bz) || (ai && bi)) return {8'h04, 32'h7FC00000};
    if (ai) return {8'h02, s, 31'h7F800000};
    if (bz) return {8'h42, s, 31'h7F800000};
    if (az || bi) return {8'h01, s, 31'h0};
    e   = ea - eb + 127;
    na  = longint'({1'b1, av[22:0]});
    den = longint'({1'b1, bv[22:0]});
    if (na >= den) num = na << 23;
    else begin
      num = na << 24;
      e = e - 1;
    end
    n  = num / den;
    rm = num % den;
    exact = (rm == 0);
    above = (2 * rm > den);
    tie   = (2 * rm == den);
    case (rv)
      3'd0:    up = above || (tie && n[0]);
      3'd1:    up = 1'b0;
      3'd2:    up = !s && !exact;
      3'd3:    up = s && !exact;
      3'd4:    up = above || (tie && !s);
      default: up = !exact;
    endcase
    n = n + longint'(up);
    if (n == 64'h1000000) begin
      n = n >> 1;
      e = e + 1;
    end
    away = ((rv == 3'd2) && !s) || ((rv == 3'd3) && s);
    if (e >= 255) begin
      if (rv == 3'd0 || rv == 3'd4 || rv == 3'd5 || away) return {8'h32, s, 31'h7F800000};
      return {8'h30, s, 31'h7F7FFFFF};
    end
    if (e <= 0) begin
      if (rv == 3'd5 || away) return {8'h28, s, 31'h00800000};
      return {8'h29, s, 31'h0};
    end
    return {exact ? 8'h00 : 8'h20, s, 8'(e), 23'(n)};
  endfunction

  function automatic logic [31:0] rand_fp(input int kind);
    logic [31:0] v;
    case (kind)
      0, 1, 2, 3, 4: v = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      5, 6:          v = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      7:             v = $urandom;
      default: begin
        case ($urandom_range(0, 6))
          0:       v = 32'h00000000;
          1:       v = 32'h80000000;
          2:       v = 32'h7F800000;
          3:       v = 32'hFF800000;
          4:       v = 32'h7FC00001;
          5:       v = 32'h00000123;
          default: v = 32'h7F7FFFFF;
        endcase
      end
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] rv,
                        output logic [31:0] zo, output logic [7:0] so, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (dut_if.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    dut_if.a = av;
    dut_if.b = bv;
    dut_if.rnd = rv;
    dut_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_if.in_valid = 1'b0;
    lat = 1;
    while (dut_if.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    zo = dut_if.z;
    so = dut_if.status;
    checks++;
    if (lat >= 100) begin
      failures++;
      $display("FAIL op_timeout a=%h b=%h: no out_valid within %0d cycles", av, bv, lat);
    end
    dut_if.out_ready = 1'b1;
    @(negedge clk);
    dut_if.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    dut_if.in_valid = 1'b0;
    dut_if.out_ready = 1'b0;
    dut_if.a = '0;
    dut_if.b = '0;
    dut_if.rnd = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (dut_if.z !== 32'd0) begin failures++; $display("FAIL reset_z got=%h exp=0", dut_if.z); end
    if (dut_if.status !== 8'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", dut_if.status); end
    if (dut_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", dut_if.out_valid); end
    if (dut_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", dut_if.in_ready); end
    if (w_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", w_state, IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] ta[12], tb_[12], tz[12];
    logic [2:0]  tr[12];
    logic [7:0]  ts[12];
    int          tl[12];
    logic [31:0] z;
    logic [7:0]  s;
    int          lat;
    bit          lat_ok;
    ta = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F000000,
           32'h7F000000, 32'h00800000, 32'h00800000, 32'h7F800000, 32'h40000000, 32'hC0C00000};
    tb_ = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000,
            32'h3E800000, 32'h7F000000, 32'h7F000000, 32'h40000000, 32'h7F800000, 32'h40000000};
    tr = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0};
    tz = '{32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 32'h7F800000, 32'h7FC00000, 32'h7F800000,
           32'h7F7FFFFF, 32'h00000000, 32'h00800000, 32'h7F800000, 32'h00000000, 32'hC0400000};
    ts = '{8'h00, 8'h20, 8'h20, 8'h42, 8'h04, 8'h32, 8'h30, 8'h29, 8'h28, 8'h02, 8'h01, 8'h00};
    tl = '{28, 28, 28, 1, 1, 28, 28, 28, 28, 1, 1, 28};
    for (int i = 0; i < 12; i++) begin
      run_op(ta[i], tb_[i], tr[i], z, s, lat);
`ifdef FP_DIV_EARLY_TERM_EN
      lat_ok = (lat <= tl[i]);
`else
      lat_ok = (lat == tl[i]);
`endif
      checks += 3;
      if (z !== tz[i]) begin failures++; $display("FAIL dir%0d_z got=%h exp=%h", i, z, tz[i]); end
      if (s !== ts[i]) begin failures++; $display("FAIL dir%0d_status got=%h exp=%h", i, s, ts[i]); end
      if (!lat_ok) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tl[i]); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    n = 0;
    @(negedge clk);
    dut_if.a = 32'h40C00000;
    dut_if.b = 32'h40000000;
    dut_if.rnd = 3'd0;
    dut_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_if.in_valid = 1'b0;
    while (dut_if.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    dut_if.a = 32'h3F800000;
    dut_if.b = 32'h40400000;
    dut_if.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks += 4;
      if (dut_if.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc%0d got=%b exp=1", i, dut_if.out_valid); end
      if (dut_if.z !== 32'h40400000) begin failures++; $display("FAIL bp_z cyc%0d got=%h exp=40400000", i, dut_if.z); end
      if (dut_if.status !== 8'h00) begin failures++; $display("FAIL bp_status cyc%0d got=%h exp=00", i, dut_if.status); end
      if (dut_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", i, dut_if.in_ready); end
      @(negedge clk);
    end
    dut_if.in_valid = 1'b0;
    dut_if.out_ready = 1'b1;
    @(negedge clk);
    dut_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (dut_if.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_out_valid cyc%0d got=%b exp=0", i, dut_if.out_valid); end
      if (dut_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_drain_in_ready cyc%0d got=%b exp=1", i, dut_if.in_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] z;
    logic [7:0]  s;
    int          lat;
    @(negedge clk);
    dut_if.a = 32'h3F800000;
    dut_if.b = 32'h40400000;
    dut_if.rnd = 3'd0;
    dut_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_if.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (dut_if.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", dut_if.out_valid); end
    if (dut_if.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", dut_if.in_ready); end
    if (w_state !== IDLE) begin failures++; $display("FAIL rstmid_state got=%0d exp=%0d", w_state, IDLE); end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h40C00000, 32'h40000000, 3'd0, z, s, lat);
    checks += 3;
    if (z !== 32'h40400000) begin failures++; $display("FAIL rstmid_after_z got=%h exp=40400000", z); end
    if (s !== 8'h00) begin failures++; $display("FAIL rstmid_after_status got=%h exp=00", s); end
`ifdef FP_DIV_EARLY_TERM_EN
    if (lat > 28) begin failures++; $display("FAIL rstmid_after_latency got=%0d exp<=28", lat); end
`else
    if (lat != 28) begin failures++; $display("FAIL rstmid_after_latency got=%0d exp=28", lat); end
`endif
  endtask

  task automatic test_random;
    logic [31:0] av, bv, z;
    logic [2:0]  rv;
    logic [7:0]  s;
    logic [39:0] e;
    int          lat;
    for (int i = 0; i < 150; i++) begin
      av = rand_fp($urandom_range(0, 8));
      bv = rand_fp($urandom_range(0, 8));
      rv = 3'($urandom_range(0, 5));
      e  = model(av, bv, rv);
      run_op(av, bv, rv, z, s, lat);
      checks += 2;
      if (z !== e[31:0]) begin failures++; $display("FAIL rand%0d_z a=%h b=%h rnd=%0d got=%h exp=%h", i, av, bv, rv, z, e[31:0]); end
      if (s !== e[39:32]) begin failures++; $display("FAIL rand%0d_status a=%h b=%h rnd=%0d got=%h exp=%h", i, av, bv, rv, s, e[39:32]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] av[8], bv[8];
    logic [2:0]  rv[8];
    int          acc_t[8];
    int          got;
    for (int i = 0; i < 8; i++) begin
      av[i] = rand_fp(0);
      bv[i] = rand_fp(1);
      rv[i] = 3'($urandom_range(0, 5));
      acc_t[i] = 0;
    end
    got = 0;
    exp_q.delete();
    dut_if.out_ready = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int n;
          n = 0;
          dut_if.a = av[i];
          dut_if.b = bv[i];
          dut_if.rnd = rv[i];
          dut_if.in_valid = 1'b1;
          while (dut_if.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
          end
          @(posedge clk);
          exp_q.push_back(model(av[i], bv[i], rv[i]));
          @(negedge clk);
          acc_t[i] = cyc;
        end
        dut_if.in_valid = 1'b0;
      end
      begin
        logic [39:0] e;
        int t;
        t = 0;
        while (got < 8 && t < 2000) begin
          @(negedge clk);
          t++;
          if (dut_if.out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL b2b_unexpected got=%h exp=none", dut_if.z);
            end else begin
              e = exp_q.pop_front();
              if ({dut_if.status, dut_if.z} !== e) begin
                failures++;
                $display("FAIL b2b%0d_result got=%h/%h exp=%h/%h", got, dut_if.status, dut_if.z, e[39:32], e[31:0]);
              end
            end
            got++;
          end
        end
      end
    join
    dut_if.out_ready = 1'b0;
    checks++;
    if (got != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got); end
    for (int i = 1; i < 8; i++) begin
      checks++;
`ifdef FP_DIV_EARLY_TERM_EN
      if (acc_t[i] - acc_t[i-1] < 3) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp>=3", i, acc_t[i] - acc_t[i-1]); end
`else
      if (acc_t[i] - acc_t[i-1] != 29) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=29", i, acc_t[i] - acc_t[i-1]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
